mul_div_seq: RTL and testbench

- Sequencer for the HI/LO arithmetic unit.
- Accepts one multiply or divide request at a time from the control unit.
- Multiply: drives the shared combinational 32x32 Booth multiplier (mul_32) from stable operand registers and captures its 64-bit product after a fixed settle time.
- Divide: runs its own 32-iteration signed divider.
- Holds the architectural HI/LO results and signals completion with a one-cycle done pulse.

---
 rtl/mul_div_seq.sv | 144 ++++++++++++++
 tb/tb_mul_div_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_seq.sv
// rtl/mul_div_seq.sv - HI/LO sequencer: shared multiplier capture and 32-step signed restoring divider
module mul_div_seq #(
  parameter int MUL_WAIT = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV_INIT, S_DIV_RUN, S_DIV_FIX, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        dbz_q, dbz_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d, dvs_q, dvs_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d;

  logic [33:0] shift_w;
  logic        ge_w;

  // quo_q starts as |dividend| and shifts its bits out MSB-first while quotient bits shift in
  assign shift_w = {rem_q, quo_q[31]};
  assign ge_w    = (shift_w >= {2'b00, dvs_q});

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          dbz_d   = 1'b0;
          cnt_d   = 5'd0;
          state_d = op ? S_DIV_INIT : S_MUL;
        end
      end
      S_MUL: begin
        if (cnt_q == 5'(MUL_WAIT - 1)) begin
          hi_d    = mul_hi;
          lo_d    = mul_lo;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DIV_INIT: begin
        if (b_q == 32'd0) begin
          hi_d    = a_q;
          lo_d    = 32'hFFFF_FFFF;
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          quo_d   = a_q[31] ? (~a_q + 32'd1) : a_q;
          dvs_d   = b_q[31] ? (~b_q + 32'd1) : b_q;
          qneg_d  = a_q[31] ^ b_q[31];
          rneg_d  = a_q[31];
          rem_d   = 33'd0;
          cnt_d   = 5'd0;
          state_d = S_DIV_RUN;
        end
      end
      S_DIV_RUN: begin
        rem_d = ge_w ? 33'(shift_w - {2'b00, dvs_q}) : shift_w[32:0];
        quo_d = {quo_q[30:0], ge_w};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_DIV_FIX;
      end
      S_DIV_FIX: begin
        lo_d    = qneg_q ? (~quo_q + 32'd1) : quo_q;
        hi_d    = rneg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      dbz_q   <= 1'b0;
      cnt_q   <= 5'd0;
      rem_q   <= 33'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// tb/tb_mul_div_seq.sv - directed self-checking bench for mul_div_seq
module tb_mul_div_seq;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start1 = 1'b0, start3 = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = 32'd0, b = 32'd0;

  logic [31:0] mul_a1, mul_b1, mul_hi1, mul_lo1, hi1, lo1;
  logic [31:0] mul_a3, mul_b3, mul_hi3, mul_lo3, hi3, lo3;
  logic        busy1, done1, dbz1, busy3, done3, dbz3;
  logic [63:0] prod1, prod3;

  int n_cmp = 0;
  int n_err = 0;
  logic use3 = 1'b0;

  // Behavioural stand-in for the shared combinational Booth multiplier
  assign prod1 = {{32{mul_a1[31]}}, mul_a1} * {{32{mul_b1[31]}}, mul_b1};
  assign prod3 = {{32{mul_a3[31]}}, mul_a3} * {{32{mul_b3[31]}}, mul_b3};
  assign mul_hi1 = prod1[63:32];
  assign mul_lo1 = prod1[31:0];
  assign mul_hi3 = prod3[63:32];
  assign mul_lo3 = prod3[31:0];

  mul_div_seq #(.MUL_WAIT(1)) u_dut1 (
    .clk(clk), .clr(clr), .start(start1), .op(op), .a(a), .b(b),
    .mul_a(mul_a1), .mul_b(mul_b1), .mul_hi(mul_hi1), .mul_lo(mul_lo1),
    .busy(busy1), .done(done1), .hi(hi1), .lo(lo1), .div_by_zero(dbz1)
  );

  mul_div_seq #(.MUL_WAIT(3)) u_dut3 (
    .clk(clk), .clr(clr), .start(start3), .op(op), .a(a), .b(b),
    .mul_a(mul_a3), .mul_b(mul_b3), .mul_hi(mul_hi3), .mul_lo(mul_lo3),
    .busy(busy3), .done(done3), .hi(hi3), .lo(lo3), .div_by_zero(dbz3)
  );

  logic [31:0] s_mul_a, s_mul_b, s_hi, s_lo;
  logic        s_busy, s_done, s_dbz;
  assign s_mul_a = use3 ? mul_a3 : mul_a1;
  assign s_mul_b = use3 ? mul_b3 : mul_b1;
  assign s_hi    = use3 ? hi3 : hi1;
  assign s_lo    = use3 ? lo3 : lo1;
  assign s_busy  = use3 ? busy3 : busy1;
  assign s_done  = use3 ? done3 : done1;
  assign s_dbz   = use3 ? dbz3 : dbz1;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic on3, input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                        input int exp_cyc, input logic [31:0] eh, input logic [31:0] el,
                        input logic edbz);
    int cyc;
    cyc = 0;
    use3 = on3;
    @(negedge clk);
    op = o; a = aa; b = bb;
    if (on3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0; start3 = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check_val({tag, " busy c1"}, 32'(s_busy), 32'd1);
        check_val({tag, " mul_a c1"}, s_mul_a, aa);
        check_val({tag, " mul_b c1"}, s_mul_b, bb);
        check_val({tag, " dbz c1"}, 32'(s_dbz), 32'd0);
        check_val({tag, " hi held c1"}, s_hi, prev_hi);
        check_val({tag, " lo held c1"}, s_lo, prev_lo);
      end
      if (s_done) begin
        cyc = n;
        break;
      end
    end
    check_val({tag, " done cycle"}, 32'(cyc), 32'(exp_cyc));
    check_val({tag, " hi"}, s_hi, eh);
    check_val({tag, " lo"}, s_lo, el);
    check_val({tag, " dbz"}, 32'(s_dbz), 32'(edbz));
    check_val({tag, " busy at done"}, 32'(s_busy), 32'd1);
    @(negedge clk);
    check_val({tag, " done after"}, 32'(s_done), 32'd0);
    check_val({tag, " busy after"}, 32'(s_busy), 32'd0);
  endtask

  initial begin
    int ndone;
    int dcyc;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check_val("rst busy", 32'(busy1), 32'd0);
    check_val("rst done", 32'(done1), 32'd0);
    check_val("rst dbz", 32'(dbz1), 32'd0);
    check_val("rst hi", hi1, 32'd0);
    check_val("rst lo", lo1, 32'd0);
    check_val("rst mul_a", mul_a1, 32'd0);
    check_val("rst mul_b", mul_b1, 32'd0);

    run_op("mul 7*-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'd0, 32'd0,
           2, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    check_val("mul_a hold idle", mul_a1, 32'd7);
    run_op("mul min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
           2, 32'h4000_0000, 32'h0, 1'b0);
    run_op("mul w3 min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'd0, 32'd0,
           4, 32'h4000_0000, 32'h0, 1'b0);
    run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h4000_0000, 32'h0,
           35, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div 100/7", 1'b1, 32'd100, 32'd7, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           35, 32'd2, 32'd14, 1'b0);
    run_op("div by 0", 1'b1, 32'h1234_5678, 32'd0, 1'b0, 32'd2, 32'd14,
           2, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    check_val("dbz sticky idle", 32'(dbz1), 32'd1);
    run_op("mul clears dbz", 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF,
           2, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
           35, 32'h0, 32'h8000_0000, 1'b0);
    run_op("div 5/-5", 1'b1, 32'd5, 32'hFFFF_FFFB, 1'b0, 32'h0, 32'h8000_0000,
           35, 32'h0, 32'hFFFF_FFFF, 1'b0);

    // start held high through a whole divide with different operands
    use3 = 1'b0;
    ndone = 0;
    dcyc = 0;
    @(negedge clk);
    op = 1'b1; a = 32'hFFFF_FFF9; b = 32'd2; start1 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      a = 32'd100; b = 32'd7;
      if (done1) begin
        ndone++;
        dcyc = n;
        check_val("spam hi", hi1, 32'hFFFF_FFFF);
        check_val("spam lo", lo1, 32'hFFFF_FFFD);
      end
      if (n == 35) start1 = 1'b0;
    end
    check_val("spam done count", 32'(ndone), 32'd1);
    check_val("spam done cycle", 32'(dcyc), 32'd35);
    check_val("spam busy end", 32'(busy1), 32'd0);

    // clr in cycle 20 of a divide
    ndone = 0;
    @(negedge clk);
    op = 1'b1; a = 32'd100; b = 32'd7; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int n = 1; n <= 21; n++) begin
      @(negedge clk);
      if (done1) ndone++;
      if (n == 20) clr = 1'b1;
      if (n == 21) begin
        check_val("clr busy", 32'(busy1), 32'd0);
        check_val("clr hi", hi1, 32'd0);
        check_val("clr lo", lo1, 32'd0);
        clr = 1'b0;
      end
    end
    check_val("clr no done", 32'(ndone), 32'd0);
    run_op("div after clr", 1'b1, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0,
           35, 32'd2, 32'd14, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
